// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Holds the receiver FSM state encoding, the legal oversampling ratios,
// the parity-type encodings and the prescale normalisation helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Any ratio other than 8 or 32 runs the receiver at 16x.
  function automatic logic [5:0] norm_prescale(input logic [5:0] p);
    case (p)
      PRESCALE_8, PRESCALE_32: return p;
      default:                 return PRESCALE_16;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// Signal bundle between the UART frame receiver and its environment.
//   slave  : receiver side (uart_rx_frame)
//   master : line driver / parity checker / consumer side
// Handshake semantics: there is no backpressure. data_valid is a
// single-cycle pulse; p_data is valid in that cycle and holds until the
// next completed frame. parity_check_enable is a single-cycle qualifier:
// parity_err is only meaningful in the same cycle it is high.
// fsm_state exposes the receiver FSM state for observation.
interface uart_rx_frame_if #(parameter int DATA_WIDTH = 8);
  import uart_pkg::*;

  logic                  rx_in;
  logic [5:0]            prescale;
  logic                  par_en;
  logic                  par_typ;
  logic                  parity_err;
  logic                  sampled_data;
  logic                  parity_bit;
  logic                  parity_check_enable;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_err_flag;
  logic                  frame_err;
  logic                  busy;
  uart_state_e           fsm_state;

  modport slave (
    input  rx_in, prescale, par_en, par_typ, parity_err,
    output sampled_data, parity_bit, parity_check_enable, p_data,
           data_valid, par_err_flag, frame_err, busy, fsm_state
  );

  modport master (
    output rx_in, prescale, par_en, par_typ, parity_err,
    input  sampled_data, parity_bit, parity_check_enable, p_data,
           data_valid, par_err_flag, frame_err, busy, fsm_state
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// Oversampling bit sampler for the UART receiver.
// Samples rx_in around the middle of each bit period and publishes the
// result on sampled_data at edge_cnt = prescale/2+1, so it is stable from
// prescale/2+2 to the end of the bit.
// Build option: UART_RX_MAJORITY_EN selects a 2-of-3 vote over the samples
// at prescale/2-1, prescale/2 and prescale/2+1; otherwise the sample at
// prescale/2 is used. Publication timing is the same in both builds.
// Ports: clk, rst (sync, active high), rx_in (serial line), active (frame
// in progress), edge_cnt (position in bit), prescale (captured ratio),
// sampled_data (sampled bit value).
module uart_rx_sampler (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       active,
  input  logic [5:0] edge_cnt,
  input  logic [5:0] prescale,
  output logic       sampled_data
);

  logic [5:0] half;
  logic       s_mid;

  assign half = prescale >> 1;

`ifdef UART_RX_MAJORITY_EN
  logic s_early;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_early      <= 1'b0;
      s_mid        <= 1'b0;
      sampled_data <= 1'b0;
    end else if (active) begin
      if (edge_cnt == half - 6'd1) s_early <= rx_in;
      if (edge_cnt == half)        s_mid   <= rx_in;
      if (edge_cnt == half + 6'd1)
        sampled_data <= (s_early & s_mid) | (s_early & rx_in) | (s_mid & rx_in);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      s_mid        <= 1'b0;
      sampled_data <= 1'b0;
    end else if (active) begin
      if (edge_cnt == half)        s_mid        <= rx_in;
      // Held back one cycle so both builds publish at the same edge.
      if (edge_cnt == half + 6'd1) sampled_data <= s_mid;
    end
  end
`endif

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: start / DATA_WIDTH payload bits (LSB first) /
// optional parity / stop, oversampled by 8, 16 or 32.
// Ports: clk (oversampling clock), rst (sync, active high), bus
// (uart_rx_frame_if.slave: line input, configuration, parity checker
// exchange, received payload, status flags and FSM state).
// Build option: UART_RX_MAJORITY_EN (majority-vote sampling, see
// uart_rx_sampler).
// The FSM, edge counter and deserializer live here; sampling is delegated.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_frame_if.slave  bus
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [5:0]            edge_cnt;
  logic [BCW-1:0]        bit_cnt;
  logic [5:0]            ps_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  rx_prev;
  logic [DATA_WIDTH-1:0] data_sr;
  logic                  par_err_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  data_valid_q;
  logic                  par_err_flag_q;
  logic                  frame_err_q;
  logic                  sampled;

  logic bit_end;
  logic stop_end;
  logic start_fall;
  logic par_chk;

  uart_rx_sampler u_sampler (
    .clk          (clk),
    .rst          (rst),
    .rx_in        (bus.rx_in),
    .active       (state_q != IDLE),
    .edge_cnt     (edge_cnt),
    .prescale     (ps_q),
    .sampled_data (sampled)
  );

  assign bit_end    = (edge_cnt == ps_q - 6'd1);
  // STOP finishes one edge early: IDLE spends one cycle detecting the next
  // start bit, so this keeps the frame period at exactly (bits * prescale)
  // and back-to-back frames do not drift.
  assign stop_end   = (edge_cnt == ps_q - 6'd2);
  // rx_prev resets to 0, so a line held low through reset is not a start.
  assign start_fall = rx_prev & ~bus.rx_in;
  assign par_chk    = (state_q == PARITY) && bit_end;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_fall) state_d = START;
      START:   if (bit_end) state_d = sampled ? IDLE : DATA;
      DATA:    if (bit_end && (bit_cnt == LAST_BIT)) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) state_d = STOP;
      STOP:    if (stop_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      edge_cnt       <= '0;
      bit_cnt        <= '0;
      ps_q           <= PRESCALE_16;
      par_en_q       <= 1'b0;
      par_typ_q      <= PAR_EVEN;
      rx_prev        <= 1'b0;
      data_sr        <= '0;
      par_err_q      <= 1'b0;
      p_data_q       <= '0;
      data_valid_q   <= 1'b0;
      par_err_flag_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_prev      <= bus.rx_in;
      data_valid_q <= 1'b0;

      if (state_q == IDLE) begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
        if (start_fall) begin
          ps_q      <= norm_prescale(bus.prescale);
          par_en_q  <= bus.par_en;
          par_typ_q <= bus.par_typ;
          par_err_q <= 1'b0;
        end
      end else if (bit_end || (state_d != state_q)) begin
        edge_cnt <= '0;
      end else begin
        edge_cnt <= edge_cnt + 6'd1;
      end

      if ((state_q == DATA) && bit_end) begin
        data_sr[bit_cnt] <= sampled;
        bit_cnt          <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
      end

      // The checker reports 1 whenever it is not enabled; only the strobe
      // cycle carries a real result.
      if (par_chk && bus.parity_err) par_err_q <= 1'b1;

      if ((state_q == STOP) && stop_end) begin
        p_data_q       <= data_sr;
        par_err_flag_q <= par_err_q;
        frame_err_q    <= ~sampled;
        data_valid_q   <= ~par_err_q & sampled;
      end
    end
  end

  assign bus.sampled_data        = sampled;
  assign bus.parity_bit          = (^data_sr) ^ par_typ_q;
  assign bus.parity_check_enable = par_chk;
  assign bus.p_data              = p_data_q;
  assign bus.data_valid          = data_valid_q;
  assign bus.par_err_flag        = par_err_flag_q;
  assign bus.frame_err           = frame_err_q;
  assign bus.busy                = (state_q != IDLE);
  assign bus.fsm_state           = state_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: drives serial frames, models the downstream
// parity checker, and scores received payloads against an expected queue.
module tb_uart_rx_frame;
  import uart_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst;

  uart_rx_frame_if #(.DATA_WIDTH(W)) bus ();

  uart_rx_frame #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Downstream parity checker: compares the received parity bit with the
  // expected one, and reports 1 when not enabled.
  assign bus.parity_err = bus.parity_check_enable ? (bus.sampled_data ^ bus.parity_bit) : 1'b1;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, required end of sequence");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int dv_count = 0;
  int pce_count = 0;
  int n_good   = 0;
  int dv_cycles[$];
  logic dv_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      dv_prev = 1'b0;
    end else begin
      if (bus.parity_check_enable) pce_count++;
      if (bus.data_valid) begin
        dv_count++;
        dv_cycles.push_back(cycle);
        check_eq("dv_width", dv_prev, 1'b0);
        check_eq("dv_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check_eq("p_data", bus.p_data, exp_q.pop_front());
        check_eq("dv_par_flag", bus.par_err_flag, 1'b0);
        check_eq("dv_frame_flag", bus.frame_err, 1'b0);
      end
      dv_prev = bus.data_valid;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic int eff_ps(input logic [5:0] p);
    if (p == 6'd8 || p == 6'd32) return int'(p);
    return 16;
  endfunction

  task automatic idle(input int n);
    bus.rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input int ps);
    bus.rx_in = b;
    repeat (ps) @(negedge clk);
  endtask

  // Configuration inputs are scrambled after the start bit; the receiver
  // must keep using the values present at the start.
  task automatic send_frame(input logic [W-1:0] d, input logic [5:0] ps_in, input logic pe,
                            input logic pt, input logic bad_par, input logic stop_b,
                            input logic expect_good);
    int ps;
    ps = eff_ps(ps_in);
    bus.prescale = ps_in;
    bus.par_en   = pe;
    bus.par_typ  = pt;
    if (expect_good) begin
      exp_q.push_back(d);
      n_good++;
    end
    drive_bit(1'b0, ps);
    bus.prescale = 6'd0;
    bus.par_en   = ~pe;
    bus.par_typ  = ~pt;
    for (int i = 0; i < W; i++) drive_bit(d[i], ps);
    if (pe) drive_bit((^d) ^ pt ^ bad_par, ps);
    drive_bit(stop_b, ps);
  endtask

  // ---------------- sequence ----------------
  int dv0, pce0, diff;
  logic [W-1:0] pd_snap;
  logic pf_snap, fe_snap;
  logic [5:0] ps_tab [3];

  initial begin
    ps_tab[0] = 6'd8; ps_tab[1] = 6'd16; ps_tab[2] = 6'd32;
    rst = 1'b1;
    bus.rx_in = 1'b1;
    bus.prescale = 6'd16;
    bus.par_en = 1'b0;
    bus.par_typ = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_p_data", bus.p_data, '0);
    check_eq("rst_dv", bus.data_valid, 1'b0);
    check_eq("rst_pce", bus.parity_check_enable, 1'b0);
    check_eq("rst_par_flag", bus.par_err_flag, 1'b0);
    check_eq("rst_frame_err", bus.frame_err, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_sampled", bus.sampled_data, 1'b0);
    check_eq("rst_state", bus.fsm_state, IDLE);

    // Good frame, even parity, 8x
    idle(5);
    pce0 = pce_count;
    send_frame(8'hA5, 6'd8, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1'b1);
    idle(4);
    check_eq("good_par_flag", bus.par_err_flag, 1'b0);
    check_eq("good_frame_err", bus.frame_err, 1'b0);
    check_eq("good_pce_count", pce_count - pce0, 1);
    check_eq("good_dv_count", dv_count, 1);

    // Same frame, wrong parity bit
    dv0 = dv_count;
    pce0 = pce_count;
    send_frame(8'hA5, 6'd8, 1'b1, PAR_EVEN, 1'b1, 1'b1, 1'b0);
    idle(4);
    check_eq("perr_flag", bus.par_err_flag, 1'b1);
    check_eq("perr_frame_err", bus.frame_err, 1'b0);
    check_eq("perr_no_dv", dv_count - dv0, 0);
    check_eq("perr_pce_count", pce_count - pce0, 1);

    // Bad stop bit, no parity, 16x
    dv0 = dv_count;
    pce0 = pce_count;
    send_frame(8'h3C, 6'd16, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1'b0);
    check_eq("ferr_state", bus.fsm_state, IDLE);
    idle(4);
    check_eq("ferr_flag", bus.frame_err, 1'b1);
    check_eq("ferr_par_flag", bus.par_err_flag, 1'b0);
    check_eq("ferr_no_dv", dv_count - dv0, 0);
    check_eq("ferr_no_pce", pce_count - pce0, 0);
    check_eq("ferr_busy", bus.busy, 1'b0);

    // 3-cycle glitch at 16x
    idle(10);
    dv0 = dv_count;
    pd_snap = bus.p_data;
    pf_snap = bus.par_err_flag;
    fe_snap = bus.frame_err;
    bus.prescale = 6'd16;
    bus.rx_in = 1'b0;
    repeat (3) @(negedge clk);
    bus.rx_in = 1'b1;
    repeat (13) @(negedge clk);
    check_eq("glitch_busy_in_start", bus.busy, 1'b1);
    @(negedge clk);
    check_eq("glitch_busy_dropped", bus.busy, 1'b0);
    idle(20);
    check_eq("glitch_p_data", bus.p_data, pd_snap);
    check_eq("glitch_par_flag", bus.par_err_flag, pf_snap);
    check_eq("glitch_frame_err", bus.frame_err, fe_snap);
    check_eq("glitch_no_dv", dv_count - dv0, 0);

    // Illegal prescale runs at 16x; odd parity
    send_frame(8'h96, 6'd20, 1'b1, PAR_ODD, 1'b0, 1'b1, 1'b1);
    idle(4);
    check_eq("ps20_frame_err_cleared", bus.frame_err, 1'b0);
    check_eq("ps20_par_flag", bus.par_err_flag, 1'b0);

    // Back-to-back frames at 32x
    idle(8);
    send_frame(8'h01, 6'd32, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1);
    send_frame(8'hFF, 6'd32, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1);
    idle(4);
    check_eq("b2b_dv_seen", dv_cycles.size() >= 2, 1'b1);
    if (dv_cycles.size() >= 2) begin
      diff = dv_cycles[dv_cycles.size()-1] - dv_cycles[dv_cycles.size()-2];
      check_eq("b2b_spacing", diff, 320);
    end

    // Random good frames
    for (int k = 0; k < 4; k++) begin
      send_frame(W'($urandom_range(0, 255)), ps_tab[$urandom_range(0, 2)],
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b1);
      idle($urandom_range(0, 6));
    end
    idle(4);

    // Reset in the middle of DATA bit 4
    dv0 = dv_count;
    bus.prescale = 6'd16;
    bus.par_en = 1'b0;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 16);
    bus.rx_in = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("pre_rst_state", bus.fsm_state, DATA);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_p_data", bus.p_data, '0);
    check_eq("mid_rst_dv", bus.data_valid, 1'b0);
    check_eq("mid_rst_pce", bus.parity_check_enable, 1'b0);
    check_eq("mid_rst_par_flag", bus.par_err_flag, 1'b0);
    check_eq("mid_rst_frame_err", bus.frame_err, 1'b0);
    check_eq("mid_rst_busy", bus.busy, 1'b0);
    check_eq("mid_rst_sampled", bus.sampled_data, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("low_line_no_start", bus.busy, 1'b0);
    idle(10);
    check_eq("rst_abort_no_dv", dv_count - dv0, 0);
    send_frame(8'h55, 6'd16, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1'b1);
    idle(4);

    for (int t = 0; t < 200 && exp_q.size() > 0; t++) @(negedge clk);
    check_eq("queue_drained", exp_q.size(), 0);
    check_eq("dv_total", dv_count, n_good);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the number of payload bits per frame, LSB first.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, which is the oversampling clock.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 The block SHALL have port rx_in, input, 1 bit: serial line, idle high.
REQ-005 The block SHALL have port prescale, input, 6 bits: oversampling ratio; legal values 8, 16, 32.
REQ-006 The block SHALL have port par_en, input, 1 bit: a parity bit is present in the frame.
REQ-007 The block SHALL have port par_typ, input, 1 bit: 0 = even parity, 1 = odd parity.
REQ-008 The block SHALL have port parity_err, input, 1 bit: result returned by the downstream parity checker; 1 = mismatch.
REQ-009 The block SHALL have port sampled_data, output, 1 bit: current sampled bit value, fed to the checker.
REQ-010 The block SHALL have port parity_bit, output, 1 bit: expected parity computed from the received payload, fed to the checker.
REQ-011 The block SHALL have port parity_check_enable, output, 1 bit: single-cycle qualify strobe for the checker.
REQ-012 The block SHALL have port p_data, output, DATA_WIDTH bits: received payload.
REQ-013 The block SHALL have port data_valid, output, 1 bit: single-cycle pulse marking a good frame.
REQ-014 The block SHALL have port par_err_flag, output, 1 bit: the last frame had a parity error.
REQ-015 The block SHALL have port frame_err, output, 1 bit: the last frame had a bad stop bit.
REQ-016 The block SHALL have port busy, output, 1 bit: 1 whenever the FSM is not in IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP, with a 6-bit edge counter (0..prescale-1) and a bit counter.
REQ-018 A prescale value other than 8, 16 or 32 SHALL be treated as 16.
REQ-019 In IDLE, rx_in=0 SHALL move the FSM to START with edge_cnt=0.
REQ-020 The sampled bit SHALL be taken at edge_cnt = prescale/2 and SHALL be stable from edge_cnt = prescale/2+2 to the end of the bit.
REQ-021 At the end of START (edge_cnt = prescale-1), a sampled 1 SHALL be treated as a glitch: return to IDLE with no outputs changed; otherwise go to DATA.
REQ-022 In DATA, each bit end SHALL shift the sampled bit into p_data at bit index bit_cnt, LSB first.
REQ-023 After DATA_WIDTH bits, DATA SHALL go to PARITY if par_en=1, else to STOP.
REQ-024 parity_bit SHALL equal (XOR of p_data) XOR par_typ.
REQ-025 parity_check_enable SHALL be high only in PARITY, at edge_cnt = prescale-1, for exactly one cycle.
REQ-026 parity_err SHALL be sampled only in the cycle where parity_check_enable=1 and ignored at all other times, since the checker reports 1 when not enabled.
REQ-027 At the end of STOP, a sampled 0 SHALL set frame_err=1.
REQ-028 par_err_flag and frame_err SHALL be updated at the end of STOP and hold until the next frame's STOP end.
REQ-029 data_valid SHALL pulse for 1 cycle at the end of STOP only if neither error is set; p_data SHALL hold until the next frame completes.
REQ-030 From the end of STOP, the FSM SHALL go to IDLE; a start bit low in the following cycle SHALL be accepted, giving back-to-back frames without loss.
REQ-031 par_en, par_typ and prescale SHALL be captured on IDLE->START; changes mid-frame SHALL be ignored.

Reset
REQ-032 rst SHALL force state IDLE, counters 0, p_data 0, and data_valid, parity_check_enable, par_err_flag, frame_err, busy and sampled_data to 0.
REQ-033 rst asserted mid-frame SHALL abort the frame with no data_valid.
REQ-034 After rst deasserts, the block SHALL wait for a new falling edge on rx_in.

Configuration
REQ-035 With UART_RX_MAJORITY_EN defined, sampled_data SHALL be the 2-of-3 majority of samples at edge_cnt prescale/2-1, prescale/2 and prescale/2+1.
REQ-036 Without UART_RX_MAJORITY_EN, sampled_data SHALL be the single sample at prescale/2; sample timing and all other behaviour SHALL be identical.

Structure
REQ-037 A shared uart_pkg SHALL hold the FSM state enum, the PRESCALE_8/16/32 constants and the parity-type encodings.
REQ-038 Sub-module uart_rx_sampler SHALL own the oversampling, the optional majority vote and sampled_data; the FSM, edge counter and deserializer SHALL live in the top module.

Verification
REQ-039 prescale=8, par_en=1, par_typ=0, frame 0xA5 with correct parity 0, checker returns 0 -> p_data=0xA5, data_valid 1-cycle pulse, both error flags 0.
REQ-040 Same frame with a wrong parity bit, checker returns 1 during the enable strobe -> par_err_flag=1, no data_valid.
REQ-041 prescale=16, par_en=0, frame 0x3C with stop bit 0 -> frame_err=1, no data_valid, FSM back in IDLE.
REQ-042 rx_in low pulse of 3 cycles at prescale=16 -> glitch rejected, busy drops at end of START, no outputs changed.
REQ-043 Two back-to-back frames 0x01 then 0xFF at prescale=32 -> two data_valid pulses exactly 10*32 cycles apart with correct p_data.
REQ-044 rst asserted during DATA bit 4 -> all outputs 0 next cycle; the following clean frame 0x55 is received correctly.
